// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared types for the execute-stage ALU issue arbiter.
//   - port_id_t / PORT_INT / PORT_EXT : requester identifiers
//   - alu_req_t : one ALU operation as presented by a requester
//   - iss_reg_t : the one-entry issue register (operation + owner + valid)
//   The ARB_* widths are the defaults of alu_issue_arbiter.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int ARB_SEL_W   = 4;
   localparam int ARB_SHIFT_W = 5;
   localparam int ARB_XLEN    = 64;
   localparam int ARB_TAG_W   = 4;

   typedef logic port_id_t;

   localparam port_id_t PORT_INT = 1'b0;   // integer pipeline
   localparam port_id_t PORT_EXT = 1'b1;   // extension / address generation

   typedef struct packed {
      logic [ARB_SEL_W-1:0]   sel;
      logic [ARB_SHIFT_W-1:0] shift_amt;
      logic [ARB_XLEN-1:0]    a;
      logic [ARB_XLEN-1:0]    b;
      logic [ARB_TAG_W-1:0]   tag;
   } alu_req_t;

   typedef struct packed {
      logic     valid;
      port_id_t port;
      alu_req_t req;
   } iss_reg_t;

   // Port that gets priority after `p` has been served.
   function automatic port_id_t other_port(input port_id_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-input round-robin grant with its own priority pointer.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset (pointer -> port 0)
//     req[1:0]     : requesters present this cycle
//     advance      : the current grant was taken; move priority away from it
//     gnt[1:0]     : one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter2
   import alu_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   port_id_t rr_ptr;

   // A lone requester always wins; the pointer only breaks ties.
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (rr_ptr == PORT_EXT) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= PORT_INT;
      end else if (advance) begin
         rr_ptr <= other_port(port_id_t'(gnt[1]));
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//   Shares the execute-stage ALU between the integer pipeline (port 0) and the
//   extension/address-generation path (port 1). A round-robin winner is held
//   in a one-entry issue register that drives the external ALU; the ALU's
//   combinational result is returned to the owning port.
//   Ports:
//     clk, reset_n        : clock, asynchronous active-low reset
//     flush               : kill the in-flight op, block new grants this cycle
//     reqN_*              : request channel (valid/ready, sel, shift, a, b, tag)
//     rspN_*              : response channel (valid/ready, data, tag)
//     alu_enable, alu_*   : drive to the external ALU
//     alu_data_out        : combinational result from the external ALU
// -----------------------------------------------------------------------------
module alu_issue_arbiter
   import alu_arb_pkg::*;
#(
   parameter int SEL_SIZE   = ARB_SEL_W,
   parameter int SHIFT_SIZE = ARB_SHIFT_W,
   parameter int XLEN       = ARB_XLEN,
   parameter int TAG_W      = ARB_TAG_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [SEL_SIZE-1:0]   req0_sel,
   input  logic [SHIFT_SIZE-1:0] req0_shift_amt,
   input  logic [XLEN-1:0]       req0_a,
   input  logic [XLEN-1:0]       req0_b,
   input  logic [TAG_W-1:0]      req0_tag,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [SEL_SIZE-1:0]   req1_sel,
   input  logic [SHIFT_SIZE-1:0] req1_shift_amt,
   input  logic [XLEN-1:0]       req1_a,
   input  logic [XLEN-1:0]       req1_b,
   input  logic [TAG_W-1:0]      req1_tag,

   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [XLEN-1:0]       rsp0_data,
   output logic [TAG_W-1:0]      rsp0_tag,

   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [XLEN-1:0]       rsp1_data,
   output logic [TAG_W-1:0]      rsp1_tag,

   output logic                  alu_enable,
   output logic [SEL_SIZE-1:0]   alu_sel,
   output logic [SHIFT_SIZE-1:0] alu_shift_amt,
   output logic [XLEN-1:0]       alu_data_in_a,
   output logic [XLEN-1:0]       alu_data_in_b,
   input  logic [XLEN-1:0]       alu_data_out
);

   iss_reg_t   iss_p1;
   logic [1:0] req_valid;
   logic [1:0] gnt;
   logic       own_rsp_ready;
   logic       can_accept;
   logic       handshake;
   port_id_t   winner;
   alu_req_t   win_req;

   // ---- p0: arbitration and request acceptance ----
   assign req_valid     = {req1_valid, req0_valid};
   assign own_rsp_ready = (iss_p1.port == PORT_EXT) ? rsp1_ready : rsp0_ready;

   // The slot is free when empty or when its result retires this same cycle.
   // reset_n is folded in so no request is acknowledged while reset is held.
   assign can_accept = reset_n && !flush && (!iss_p1.valid || own_rsp_ready);

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_valid),
      .advance (handshake),
      .gnt     (gnt)
   );

   assign req0_ready = can_accept && gnt[0];
   assign req1_ready = can_accept && gnt[1];
   assign handshake  = req0_ready || req1_ready;
   assign winner     = port_id_t'(gnt[1]);

   always_comb begin
      win_req           = '0;
      win_req.sel       = (winner == PORT_EXT) ? req1_sel       : req0_sel;
      win_req.shift_amt = (winner == PORT_EXT) ? req1_shift_amt : req0_shift_amt;
      win_req.a         = (winner == PORT_EXT) ? req1_a         : req0_a;
      win_req.b         = (winner == PORT_EXT) ? req1_b         : req0_b;
      win_req.tag       = (winner == PORT_EXT) ? req1_tag       : req0_tag;
   end

   // ---- p1: issue register ----
   // Payload fields are only rewritten on a handshake, so the ALU inputs keep
   // their last value while the slot is empty or back-pressured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_p1 <= '0;
      end else if (handshake) begin
         iss_p1.valid <= 1'b1;
         iss_p1.port  <= winner;
         iss_p1.req   <= win_req;
      end else if (flush || (iss_p1.valid && own_rsp_ready)) begin
         iss_p1.valid <= 1'b0;
      end
   end

   // ---- p1 outputs: ALU drive and response routing ----
   assign alu_enable    = iss_p1.valid;
   assign alu_sel       = iss_p1.req.sel;
   assign alu_shift_amt = iss_p1.req.shift_amt;
   assign alu_data_in_a = iss_p1.req.a;
   assign alu_data_in_b = iss_p1.req.b;

   assign rsp0_valid = iss_p1.valid && (iss_p1.port == PORT_INT);
   assign rsp1_valid = iss_p1.valid && (iss_p1.port == PORT_EXT);

   // Data and tag are zeroed when not owned so an idle port sees quiet lines.
   assign rsp0_data = rsp0_valid ? alu_data_out   : '0;
   assign rsp1_data = rsp1_valid ? alu_data_out   : '0;
   assign rsp0_tag  = rsp0_valid ? iss_p1.req.tag : '0;
   assign rsp1_tag  = rsp1_valid ? iss_p1.req.tag : '0;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;

   logic        clk = 1'b0;
   logic        reset_n, flush;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_sel, req1_sel;
   logic [4:0]  req0_shift_amt, req1_shift_amt;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_tag, req1_tag;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [63:0] rsp0_data, rsp1_data;
   logic [3:0]  rsp0_tag, rsp1_tag;
   logic        alu_enable;
   logic [3:0]  alu_sel;
   logic [4:0]  alu_shift_amt;
   logic [63:0] alu_data_in_a, alu_data_in_b, alu_data_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] tag_ctr = 4'd0;

   typedef struct {
      logic [3:0]  tag;
      logic [63:0] data;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   // Stand-in for the external ALU.
   function automatic logic [63:0] alu_model(input logic [3:0] s, input logic [4:0] sh,
                                             input logic [63:0] a, input logic [63:0] b);
      case (s)
         OP_ADD:  alu_model = a + b;
         OP_SUB:  alu_model = a - b;
         OP_AND:  alu_model = a & b;
         OP_OR:   alu_model = a | b;
         OP_XOR:  alu_model = a ^ b;
         OP_SLL:  alu_model = a << sh;
         default: alu_model = ~a;
      endcase
   endfunction

   assign alu_data_out = alu_model(alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b);

   alu_issue_arbiter dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
      .req0_shift_amt(req0_shift_amt), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
      .req1_shift_amt(req1_shift_amt), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
      .alu_enable(alu_enable), .alu_sel(alu_sel), .alu_shift_amt(alu_shift_amt),
      .alu_data_in_a(alu_data_in_a), .alu_data_in_b(alu_data_in_b), .alu_data_out(alu_data_out)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic new_payload(input int p);
      logic [3:0]  s;
      logic [4:0]  sh;
      logic [63:0] a, b;
      s  = 4'($urandom_range(5, 0));
      sh = 5'($urandom_range(31, 0));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      tag_ctr = tag_ctr + 4'd1;
      if (p == 0) begin
         req0_valid = 1'b1; req0_sel = s; req0_shift_amt = sh;
         req0_a = a; req0_b = b; req0_tag = tag_ctr;
      end else begin
         req1_valid = 1'b1; req1_sel = s; req1_shift_amt = sh;
         req1_a = a; req1_b = b; req1_tag = tag_ctr;
      end
   endtask

   // Expected result of the request currently presented on port p.
   task automatic push(input int p);
      exp_t e;
      if (p == 0) begin
         e.tag  = req0_tag;
         e.data = alu_model(req0_sel, req0_shift_amt, req0_a, req0_b);
         q0.push_back(e);
      end else begin
         e.tag  = req1_tag;
         e.data = alu_model(req1_sel, req1_shift_amt, req1_a, req1_b);
         q1.push_back(e);
      end
   endtask

   task automatic pop_chk(input int p);
      exp_t e;
      if (p == 0) begin
         chk("rsp0_valid", 64'(rsp0_valid), 64'd1);
         chk("q0_has_entry", 64'(q0.size() != 0), 64'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("rsp0_tag", 64'(rsp0_tag), 64'(e.tag));
            chk("rsp0_data", rsp0_data, e.data);
         end
      end else begin
         chk("rsp1_valid", 64'(rsp1_valid), 64'd1);
         chk("q1_has_entry", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("rsp1_tag", 64'(rsp1_tag), 64'(e.tag));
            chk("rsp1_data", rsp1_data, e.data);
         end
      end
   endtask

   // Requester rule: a valid request holds valid and payload until accepted.
   logic         pend0 = 1'b0, pend1 = 1'b0;
   logic [140:0] hold0, hold1;
   always @(negedge clk) begin
      if (reset_n && pend0) begin
         n_cmp++;
         assert (req0_valid && ({req0_sel, req0_shift_amt, req0_a, req0_b, req0_tag} === hold0))
         else begin
            n_bad++;
            $error("FAIL req0_hold: observed valid %0b expected held request", req0_valid);
         end
      end
      if (reset_n && pend1) begin
         n_cmp++;
         assert (req1_valid && ({req1_sel, req1_shift_amt, req1_a, req1_b, req1_tag} === hold1))
         else begin
            n_bad++;
            $error("FAIL req1_hold: observed valid %0b expected held request", req1_valid);
         end
      end
      pend0 <= reset_n && req0_valid && !req0_ready;
      pend1 <= reset_n && req1_valid && !req1_ready;
      hold0 <= {req0_sel, req0_shift_amt, req0_a, req0_b, req0_tag};
      hold1 <= {req1_sel, req1_shift_amt, req1_a, req1_b, req1_tag};
   end

   initial begin
      int g;
      reset_n = 1'b0; flush = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      new_payload(0);
      new_payload(1);

      // Reset: requests present but nothing acknowledged, all outputs quiet.
      smp();
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_req1_ready", 64'(req1_ready), 64'd0);
      chk("rst_alu_enable", 64'(alu_enable), 64'd0);
      chk("rst_alu_sel", 64'(alu_sel), 64'd0);
      chk("rst_alu_shift", 64'(alu_shift_amt), 64'd0);
      chk("rst_alu_a", alu_data_in_a, 64'd0);
      chk("rst_alu_b", alu_data_in_b, 64'd0);
      chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("rst_rsp0_data", rsp0_data, 64'd0);
      chk("rst_rsp1_data", rsp1_data, 64'd0);
      chk("rst_rsp0_tag", 64'(rsp0_tag), 64'd0);
      chk("rst_rsp1_tag", 64'(rsp1_tag), 64'd0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0; reset_n = 1'b1;
      smp();
      chk("idle_alu_enable", 64'(alu_enable), 64'd0);

      // Single port-0 ADD 5+7 tag 3, then a lone port-1 op.
      tick();
      req0_valid = 1'b1; req0_sel = OP_ADD; req0_shift_amt = 5'd0;
      req0_a = 64'd5; req0_b = 64'd7; req0_tag = 4'd3;
      smp();
      chk("t1_req0_ready", 64'(req0_ready), 64'd1);
      chk("t1_req1_ready", 64'(req1_ready), 64'd0);
      push(0);
      tick();
      req0_valid = 1'b0;
      smp();
      chk("t1_alu_enable", 64'(alu_enable), 64'd1);
      chk("t1_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("t1_add_result", rsp0_data, 64'd12);
      pop_chk(0);
      tick();
      new_payload(1);
      smp();
      chk("t1_rsp0_retired", 64'(rsp0_valid), 64'd0);
      chk("t1_req1_ready", 64'(req1_ready), 64'd1);
      push(1);
      tick();
      req1_valid = 1'b0;
      smp();
      chk("t1_rsp0_idle", 64'(rsp0_valid), 64'd0);
      pop_chk(1);

      // Both ports continuously valid: strict alternation starting at port 0.
      tick();
      new_payload(0);
      new_payload(1);
      for (int i = 0; i < 6; i++) begin
         smp();
         g = i % 2;
         chk("t2_req0_ready", 64'(req0_ready), 64'(g == 0));
         chk("t2_req1_ready", 64'(req1_ready), 64'(g == 1));
         if (i > 0) begin
            pop_chk(1 - g);
            if (g == 0) chk("t2_rsp0_idle", 64'(rsp0_valid), 64'd0);
            else        chk("t2_rsp1_idle", 64'(rsp1_valid), 64'd0);
         end
         push(g);
         tick();
         if (i < 5) new_payload(g);
      end
      req1_valid = 1'b0;
      smp();
      chk("t2_tail_req0_ready", 64'(req0_ready), 64'd1);
      chk("t2_tail_req1_ready", 64'(req1_ready), 64'd0);
      pop_chk(1);
      push(0);
      tick();
      req0_valid = 1'b0;
      smp();
      pop_chk(0);

      // Backpressure on port 1 for three cycles with req0 waiting.
      tick();
      new_payload(1);
      rsp1_ready = 1'b0;
      smp();
      chk("t3_req1_ready", 64'(req1_ready), 64'd1);
      push(1);
      tick();
      req1_valid = 1'b0;
      new_payload(0);
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("t3_rsp1_valid", 64'(rsp1_valid), 64'd1);
         chk("t3_rsp1_data", rsp1_data, q1[0].data);
         chk("t3_rsp1_tag", 64'(rsp1_tag), 64'(q1[0].tag));
         chk("t3_req0_ready", 64'(req0_ready), 64'd0);
         chk("t3_req1_ready", 64'(req1_ready), 64'd0);
         tick();
      end
      rsp1_ready = 1'b1;
      smp();
      pop_chk(1);
      chk("t3_retire_accept", 64'(req0_ready), 64'd1);
      push(0);
      tick();
      req0_valid = 1'b0;
      smp();
      pop_chk(0);
      chk("t3_rsp1_idle", 64'(rsp1_valid), 64'd0);

      // Flush with a port-1 op in flight and req0 waiting.
      tick();
      new_payload(1);
      smp();
      chk("t4_req1_ready", 64'(req1_ready), 64'd1);
      push(1);
      tick();
      req1_valid = 1'b0; rsp1_ready = 1'b0; flush = 1'b1;
      new_payload(0);
      smp();
      chk("t4_flush_req0_ready", 64'(req0_ready), 64'd0);
      chk("t4_flush_req1_ready", 64'(req1_ready), 64'd0);
      pop_chk(1);
      tick();
      flush = 1'b0; rsp1_ready = 1'b1;
      new_payload(1);
      smp();
      chk("t4_post_alu_enable", 64'(alu_enable), 64'd0);
      chk("t4_post_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("t4_post_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("t4_post_req0_ready", 64'(req0_ready), 64'd1);
      chk("t4_post_req1_ready", 64'(req1_ready), 64'd0);
      push(0);
      tick();
      req0_valid = 1'b0;
      smp();
      pop_chk(0);
      chk("t4_req1_ready", 64'(req1_ready), 64'd1);
      push(1);
      tick();
      req1_valid = 1'b0;
      smp();
      pop_chk(1);

      // Asynchronous reset mid-cycle with an op in flight.
      tick();
      new_payload(0);
      rsp0_ready = 1'b0;
      smp();
      chk("t5_req0_ready", 64'(req0_ready), 64'd1);
      push(0);
      tick();
      req0_valid = 1'b0;
      new_payload(1);
      smp();
      chk("t5_rsp0_valid", 64'(rsp0_valid), 64'd1);
      chk("t5_bp_req1_ready", 64'(req1_ready), 64'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_rst_alu_enable", 64'(alu_enable), 64'd0);
      chk("t5_rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("t5_rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("t5_rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("t5_rst_req1_ready", 64'(req1_ready), 64'd0);
      chk("t5_rst_rsp0_data", rsp0_data, 64'd0);
      q0.delete();
      tick();
      reset_n = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      new_payload(0);
      smp();
      chk("t5_first_req0_ready", 64'(req0_ready), 64'd1);
      chk("t5_first_req1_ready", 64'(req1_ready), 64'd0);
      push(0);
      tick();
      req0_valid = 1'b0;
      smp();
      pop_chk(0);
      chk("t5_req1_ready", 64'(req1_ready), 64'd1);
      push(1);
      tick();
      req1_valid = 1'b0;
      smp();
      pop_chk(1);
      chk("end_q0_empty", 64'(q0.size()), 64'd0);
      chk("end_q1_empty", 64'(q1.size()), 64'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
